// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: branch counter encodings, BTB entry layout and reset PC.
package fetch_pkg;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } btb_ctr_e;

    // Tag is held at full word-address width; upper bits stay zero for larger tables.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [29:0] target;
        btb_ctr_e    ctr;
    } btb_entry_t;

    function automatic btb_ctr_e ctr_next(input btb_ctr_e cur, input logic taken);
        btb_ctr_e nxt;
        case (cur)
            STRONG_NT: nxt = taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   nxt = taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    nxt = taken ? STRONG_T : WEAK_NT;
            STRONG_T:  nxt = taken ? STRONG_T : WEAK_T;
            default:   nxt = WEAK_T;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/npc_fetch_unit_if.sv
// Fetch-stage control/result bundle: pipeline (master) drives redirects and BTB
// updates, the fetch unit (slave) returns the fetch PC and its prediction.
interface npc_fetch_unit_if;
    logic        stall_f;
    logic        redirect_e;
    logic [31:0] redirect_pc_e;
    logic        jal_d;
    logic [31:0] jal_pc_d;
    logic        btb_upd_e;
    logic [31:0] btb_pc_e;
    logic [31:0] btb_tgt_e;
    logic        btb_taken_e;
    logic [31:0] pc_f;
    logic        pred_taken_f;
    logic [31:0] pred_pc_f;

    modport master (
        output stall_f, redirect_e, redirect_pc_e, jal_d, jal_pc_d,
               btb_upd_e, btb_pc_e, btb_tgt_e, btb_taken_e,
        input  pc_f, pred_taken_f, pred_pc_f
    );

    modport slave (
        input  stall_f, redirect_e, redirect_pc_e, jal_d, jal_pc_d,
               btb_upd_e, btb_pc_e, btb_tgt_e, btb_taken_e,
        output pc_f, pred_taken_f, pred_pc_f
    );
endinterface

// File: rtl/npc_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters; one lookup
// port (pre-update contents) and one update port written on the clock edge.
module npc_btb
    import fetch_pkg::*;
#(
    parameter int BTB_ENTRIES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] lookup_pc,
    output logic        pred_taken,
    output logic [31:0] pred_tgt,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_tgt,
    input  logic        upd_taken
);
    localparam int IW = $clog2(BTB_ENTRIES);

    btb_entry_t        btb_r [BTB_ENTRIES];
    logic [IW-1:0]     lk_idx_s;
    logic [IW-1:0]     up_idx_s;
    logic [29:0]       lk_tag_s;
    logic [29:0]       up_tag_s;
    btb_entry_t        lk_ent_s;
    btb_entry_t        up_ent_s;
    btb_entry_t        new_ent_s;
    logic              up_hit_s;
    logic              wr_s;
    logic              unused_s;

    assign lk_idx_s = lookup_pc[2+IW-1:2];
    assign up_idx_s = upd_pc[2+IW-1:2];
    assign lk_tag_s = 30'(lookup_pc >> (2 + IW));
    assign up_tag_s = 30'(upd_pc >> (2 + IW));
    assign lk_ent_s = btb_r[lk_idx_s];
    assign up_ent_s = btb_r[up_idx_s];
    assign up_hit_s = up_ent_s.valid && (up_ent_s.tag == up_tag_s);

    assign pred_taken = lk_ent_s.valid && (lk_ent_s.tag == lk_tag_s) && lk_ent_s.ctr[1];
    assign pred_tgt   = {lk_ent_s.target, 2'b00};
    assign unused_s   = ^{lookup_pc[1:0], upd_pc[1:0], upd_tgt[1:0]};

    // Build the replacement entry: train on hit, allocate on taken miss.
    always_comb begin
        new_ent_s = up_ent_s;
        wr_s      = 1'b0;
        if (upd_en && up_hit_s) begin
            wr_s          = 1'b1;
            new_ent_s.ctr = ctr_next(up_ent_s.ctr, upd_taken);
            if (upd_taken) begin
                new_ent_s.target = upd_tgt[31:2];
            end else begin
                new_ent_s.target = up_ent_s.target;
            end
        end else if (upd_en && upd_taken) begin
            wr_s             = 1'b1;
            new_ent_s.valid  = 1'b1;
            new_ent_s.tag    = up_tag_s;
            new_ent_s.target = upd_tgt[31:2];
            new_ent_s.ctr    = WEAK_T;
        end else begin
            wr_s = 1'b0;
        end
    end

    // Table storage; reset clears every valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_r[i] <= '0;
            end
        end else if (wr_s) begin
            btb_r[up_idx_s] <= new_ent_s;
        end
    end

endmodule

// File: rtl/npc_fetch_unit.sv
// Fetch-PC register and next-PC selection (redirect > stall > JAL > BTB > PC+4).
// Optional branch target buffer enabled by defining NPC_BTB_EN.
module npc_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = FETCH_RESET_PC,
    parameter int          BTB_ENTRIES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    npc_fetch_unit_if.slave  bus
);
    logic [31:0] pc_r;
    logic [31:0] next_pc_s;
    logic [31:0] pred_pc_s;
    logic [31:0] btb_tgt_s;
    logic        btb_taken_s;
    logic        unused_ctl_s;

`ifdef NPC_BTB_EN
    npc_btb #(.BTB_ENTRIES(BTB_ENTRIES)) u_btb (
        .clk       (clk),
        .rst_n     (rst_n),
        .lookup_pc (pc_r),
        .pred_taken(btb_taken_s),
        .pred_tgt  (btb_tgt_s),
        .upd_en    (bus.btb_upd_e),
        .upd_pc    (bus.btb_pc_e),
        .upd_tgt   (bus.btb_tgt_e),
        .upd_taken (bus.btb_taken_e)
    );
`else
    logic unused_btb_s;
    assign btb_taken_s  = 1'b0;
    assign btb_tgt_s    = 32'h0000_0000;
    assign unused_btb_s = ^{bus.btb_upd_e, bus.btb_pc_e, bus.btb_tgt_e,
                            bus.btb_taken_e, BTB_ENTRIES[0]};
`endif

    assign pred_pc_s    = btb_taken_s ? btb_tgt_s : pc_r + 32'd4;
    assign unused_ctl_s = ^{bus.redirect_pc_e[1:0], bus.jal_pc_d[1:0]};

    // JAL is dropped while stalled: the held ID instruction presents it again.
    always_comb begin
        next_pc_s = pred_pc_s;
        if (bus.redirect_e) begin
            next_pc_s = {bus.redirect_pc_e[31:2], 2'b00};
        end else if (bus.stall_f) begin
            next_pc_s = pc_r;
        end else if (bus.jal_d) begin
            next_pc_s = {bus.jal_pc_d[31:2], 2'b00};
        end else begin
            next_pc_s = pred_pc_s;
        end
    end

    // Architectural fetch PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= next_pc_s;
        end
    end

    assign bus.pc_f         = pc_r;
    assign bus.pred_taken_f = btb_taken_s;
    assign bus.pred_pc_f    = pred_pc_s;

endmodule

// File: tb/tb_npc_fetch_unit.sv
// Scoreboard bench for npc_fetch_unit: each step queues the expected post-edge
// fetch state; a monitor pops and compares one entry after every rising edge.
module tb_npc_fetch_unit;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    npc_fetch_unit_if bus();

    npc_fetch_unit #(.RESET_PC(32'h0000_0000), .BTB_ENTRIES(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        tk;
        logic [31:0] ppc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare queued expectations against the DUT after each edge.
    always begin
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("pc_f", bus.pc_f, mon_e.pc);
            chk("pred_taken_f", {31'd0, bus.pred_taken_f}, {31'd0, mon_e.tk});
            chk("pred_pc_f", bus.pred_pc_f, mon_e.ppc);
        end
    end

    task automatic drive(input logic rd, input logic [31:0] rdpc, input logic st,
                         input logic jl, input logic [31:0] jpc, input logic up,
                         input logic [31:0] upc, input logic [31:0] utgt, input logic utk);
        bus.redirect_e    = rd;
        bus.redirect_pc_e = rdpc;
        bus.stall_f       = st;
        bus.jal_d         = jl;
        bus.jal_pc_d      = jpc;
        bus.btb_upd_e     = up;
        bus.btb_pc_e      = upc;
        bus.btb_tgt_e     = utgt;
        bus.btb_taken_e   = utk;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic rd, input logic [31:0] rdpc, input logic st,
                        input logic jl, input logic [31:0] jpc, input logic up,
                        input logic [31:0] upc, input logic [31:0] utgt, input logic utk,
                        input logic [31:0] epc, input logic etk, input logic [31:0] eppc);
        exp_t e;
        drive(rd, rdpc, st, jl, jpc, up, upc, utgt, utk);
        e.pc  = epc;
        e.tk  = etk;
        e.ppc = eppc;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic seq(input logic rd, input logic [31:0] rdpc, input logic st,
                       input logic jl, input logic [31:0] jpc, input logic [31:0] epc);
        step(rd, rdpc, st, jl, jpc, 1'b0, 32'h0, 32'h0, 1'b0, epc, 1'b0, epc + 32'd4);
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        rst_n = 1'b0;
        #12;
        chk("reset pc_f", bus.pc_f, 32'h0000_0000);
        chk("reset pred_taken_f", {31'd0, bus.pred_taken_f}, 32'h0000_0000);
        chk("reset pred_pc_f", bus.pred_pc_f, 32'h0000_0004);
        @(negedge clk);
        rst_n = 1'b1;
        seq(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0000_0004);
        seq(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0000_0008);
        seq(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0000_000C);

        // Asynchronous reset mid-cycle, with a redirect pending that must be lost.
        drive(1'b1, 32'h0000_0200, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset pc_f", bus.pc_f, 32'h0000_0000);
        chk("async reset pred_pc_f", bus.pred_pc_f, 32'h0000_0004);
        @(posedge clk);
        #1;
        chk("reset drops redirect", bus.pc_f, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;

        seq(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0000_0004);
        seq(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0000_0008);
        seq(1'b1, 32'h0000_0040, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0040);
        seq(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0040);
        seq(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0040);
        seq(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0000_0044);
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0,
             32'hFFFF_FFFC, 1'b0, 32'h0000_0000);
        seq(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0000_0000);
        seq(1'b1, 32'h0000_0103, 1'b0, 1'b0, 32'h0, 32'h0000_0100);
        seq(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0207, 32'h0000_0204);
        seq(1'b1, 32'h0000_0300, 1'b1, 1'b0, 32'h0, 32'h0000_0300);
        seq(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0000_0300);

`ifdef NPC_BTB_EN
        seq(1'b1, 32'h0000_0008, 1'b0, 1'b0, 32'h0, 32'h0000_0008);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 32'h80, 1'b1, 32'h0C, 1'b0, 32'h10);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h10, 1'b1, 32'h80);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h80, 1'b0, 32'h84);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 32'h0, 1'b0, 32'h84, 1'b0, 32'h88);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 32'h0, 1'b0, 32'h88, 1'b0, 32'h8C);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 32'h0, 1'b0, 32'h8C, 1'b0, 32'h90);
        step(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h10, 1'b0, 32'h14);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 32'h80, 1'b1, 32'h14, 1'b0, 32'h18);
        step(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 32'h80, 1'b1, 32'h10, 1'b1, 32'h80);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h30, 32'hC0, 1'b1, 32'h10, 1'b0, 32'h14);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h14, 1'b0, 32'h18);
        step(1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h30, 1'b1, 32'hC0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h30, 32'h0, 1'b0, 32'hC0, 1'b0, 32'hC4);
        step(1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 1'b1, 32'h30, 32'hE0, 1'b1, 32'h30, 1'b1, 32'hE0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h30, 32'hE0, 1'b1, 32'h30, 1'b1, 32'hE0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h30, 32'hE0, 1'b1, 32'h30, 1'b1, 32'hE0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h30, 32'h0, 1'b0, 32'h30, 1'b1, 32'hE0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hE0, 1'b0, 32'hE4);
        step(1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h30, 1'b1, 32'hE0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h400, 1'b0, 32'h0, 32'h0, 1'b0, 32'h400, 1'b0, 32'h404);
`else
        step(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 32'h80, 1'b1, 32'h10, 1'b0, 32'h14);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 32'h80, 1'b1, 32'h14, 1'b0, 32'h18);
        seq(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0000_0018);
`endif

        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/npc_fetch_unit.md
# npc_fetch_unit

Instruction-fetch stage of the RISC-V pipeline: owns the architectural fetch PC and computes the next PC from EX-stage redirects, ID-stage JAL targets, an optional branch target buffer, and sequential PC+4. Its `pc_f` drives the IF-ID segment register, which uses it as the synchronous instruction-BRAM address and as the registered PC for ID.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `BTB_ENTRIES`, 8: BTB depth; power of two, 2 to 64. Used only with `NPC_BTB_EN`.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `stall_f` input 1: hold the PC. Comes from the hazard unit.
- `redirect_e` input 1: EX resolved a control transfer whose outcome differs from the one fetched (taken branch, JALR, or BTB mispredict correction).
- `redirect_pc_e` input 32: correct next PC for `redirect_e`.
- `jal_d` input 1: ID decoded a JAL.
- `jal_pc_d` input 32: JAL target.
- `btb_upd_e` input 1: EX resolved a conditional branch; update the BTB.
- `btb_pc_e` input 32: PC of the resolved branch.
- `btb_tgt_e` input 32: target of the resolved branch.
- `btb_taken_e` input 1: resolved branch direction.
- `pc_f` output 32: current fetch PC (registered).
- `pred_taken_f` output 1: BTB predicted taken for `pc_f`.
- `pred_pc_f` output 32: predicted next PC for `pc_f`. The pipeline carries it to EX for mispredict checking.

## Operation
- Next-PC priority, highest first:
  - `redirect_e` → `redirect_pc_e`
  - `stall_f` → hold `pc_f`
  - `jal_d` → `jal_pc_d`
  - BTB hit with counter[1]=1 → stored target
  - otherwise → `pc_f`+4
- `redirect_e` overrides `stall_f`. `jal_d` is ignored while stalled, because the stalled ID instruction re-presents it.
- Every loaded PC has bits [1:0] forced to 2'b00. PC+4 wraps modulo 2^32: 32'hFFFF_FFFC goes to 0.
- `pred_pc_f` is the value the BTB/sequential path would choose, ignoring redirect, JAL and stall.
- `pred_taken_f`=1 only on a BTB hit with counter[1]=1.
- BTB lookup:
  - Direct-mapped, index = `pc_f`[2+IW-1:2] with IW = log2(`BTB_ENTRIES`).
  - Tag = `pc_f`[31:2+IW].
  - Entry contents: valid, tag, 30-bit target (word address), 2-bit saturating counter.
- BTB update on `btb_upd_e`, indexed and tagged by `btb_pc_e`:
  - Hit: counter increments if taken, decrements if not, saturating at 2'b11 / 2'b00. If taken, target := `btb_tgt_e`.
  - Miss and taken: allocate the entry (overwrite) with valid=1, counter=2'b10, new tag and target.
  - Miss and not taken: no change.
- BTB updates occur regardless of `stall_f` and `redirect_e`.

## Timing
- Reset (asynchronous assert, synchronous release with the clock):
  - `pc_f` = `RESET_PC`.
  - All BTB valid bits = 0, so `pred_taken_f` = 0 and `pred_pc_f` = `RESET_PC`+4.
  - Counters and targets are don't-care.
- Reset asserted mid-operation discards any pending redirect or update in the same cycle.
- Redirect/JAL latency: input high in cycle n → `pc_f` = target in cycle n+1. The corresponding instruction word reaches ID in cycle n+2 (synchronous BRAM).
- `stall_f` high for k cycles holds `pc_f` for exactly those k cycles.
- Lookup and update to the same index in the same cycle: the lookup sees pre-update contents; the update is visible from the next cycle.
- All outputs are functions of registered state only (no input→output combinational path), except that none exists: `pred_*` derive from `pc_f` and BTB state.

## Configuration
- `NPC_BTB_EN` defined: BTB instantiated as described.
- `NPC_BTB_EN` undefined:
  - No BTB storage.
  - `pred_taken_f` tied to 0 and `pred_pc_f` = `pc_f`+4.
  - `btb_*` inputs ignored.
  - Priority list without the BTB step.

## Structure
- Shared package `fetch_pkg`:
  - Counter encodings: STRONG_NT=2'b00, WEAK_NT=2'b01, WEAK_T=2'b10, STRONG_T=2'b11.
  - BTB entry struct typedef.
  - Default `RESET_PC` constant.
- One sub-module `npc_btb`: storage, lookup port and update port, parameterised by `BTB_ENTRIES`. Instantiated only under `NPC_BTB_EN`.

## Test plan
- Reset with `RESET_PC`=32'h0000_0000, release, run 3 cycles → `pc_f` = 0, 4, 8, 12. Assert `rst_n`=0 mid-cycle → `pc_f` immediately 0.
- At `pc_f`=8: `jal_d`=1 with 32'h0000_0100, same cycle as `redirect_e`=1 with 32'h0000_0040 → next `pc_f`=32'h40. Then `stall_f`=1 with `jal_d`=1 for 2 cycles → `pc_f` holds 32'h40.
- `btb_upd_e` taken at `btb_pc_e`=32'h10, tgt 32'h80 (BTB_EN) → when `pc_f`=32'h10, `pred_taken_f`=1, `pred_pc_f`=32'h80, next `pc_f`=32'h80.
- Two not-taken updates at 32'h10 → counter 2'b10→2'b01→2'b00; fetch at 32'h10 gives `pred_taken_f`=0, next `pc_f`=32'h14. Further not-taken updates stay at 2'b00.
- Aliasing with 8 entries: taken update at 32'h30 evicts the entry for 32'h10 (same index 4) → fetch of 32'h10 misses. Same-cycle lookup and update at 32'h30 → old prediction used that cycle.
- `pc_f`=32'hFFFF_FFFC, no control inputs → next `pc_f`=0. `redirect_pc_e`=32'h0000_0103 → `pc_f`=32'h100.
